// File: rtl/imm_ext_seq.sv
// Immediate-extension sequencer: selects 4/8-bit sign, 8-bit zero, or paired
// upper/lower byte extension and holds the 16-bit result until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new instruction
// WAIT_LO | upper byte captured, waiting for the lower-byte instruction
// OUT     | imm valid, held until out_ready
module imm_ext_seq #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [1:0]  imm_sel,
  output logic        imm_valid,
  input  logic        out_ready,
  output logic [15:0] imm,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       hi;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      ext_val;

  // ready is a pure state decode; gated by reset_n so it reads 0 while held in reset
  assign instr_ready = reset_n & (state != OUT);
  assign busy        = (state != IDLE);

  always_comb begin
    ext_val = 16'h0000;
    case (imm_sel)
      2'b00:   ext_val = {{12{instr[3]}}, instr[3:0]};
      2'b01:   ext_val = {{8{instr[7]}}, instr[7:0]};
      2'b10:   ext_val = {8'h00, instr[7:0]};
      default: ext_val = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      imm         <= 16'h0000;
      imm_valid   <= 1'b0;
      timeout_err <= 1'b0;
      hi          <= 8'h00;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (imm_sel == 2'b11) begin
              hi    <= instr[7:0];
              cnt   <= '0;
              state <= WAIT_LO;
            end else begin
              imm       <= ext_val;
              imm_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        WAIT_LO: begin
          // an accept on the terminal cycle completes the pair instead of timing out
          if (instr_valid) begin
            imm       <= {hi, instr[7:0]};
            imm_valid <= 1'b1;
            hi        <= 8'h00;
            cnt       <= '0;
            state     <= OUT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            hi          <= 8'h00;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            imm_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          imm_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
